// File: rtl/spi_input_frontend.sv
// spi_input_frontend: synchronise, debounce and edge-detect the raw SPI sclk/cs/mosi pins
module spi_input_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_SCLK   = 3,
    parameter int WAIT_CS     = 3,
    parameter int WAIT_MOSI   = 3,
    parameter bit SCLK_IDLE   = 1'b0,
    parameter bit GATE_EDGES  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic c_sclk,
    output logic sclk_pos,
    output logic sclk_neg,
    output logic c_cs,
    output logic cs_fall,
    output logic cs_rise,
    output logic c_mosi
);
    logic [2:0] pins;
    logic [2:0] syncd;
    logic [2:0] acc;
    logic [2:0] lvl;
    logic       sclk_en;

    assign pins = {mosi, cs, sclk};

    for (genvar g = 0; g < 3; g++) begin : ch
        localparam int W  = (g == 0) ? WAIT_SCLK : (g == 1) ? WAIT_CS : WAIT_MOSI;
        localparam bit I  = (g == 0) ? SCLK_IDLE : (g == 1);
        localparam int CW = $clog2(W + 1);
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt;
        logic                   lvl_q;
        assign syncd[g] = sync_q[SYNC_STAGES-1];
        assign acc[g]   = (syncd[g] != lvl_q) && (cnt == CW'(W - 1));
        assign lvl[g]   = lvl_q;
        // synchroniser chain plus persistence counter; level flips once a change has held W cycles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {SYNC_STAGES{I}};
                cnt    <= '0;
                lvl_q  <= I;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pins[g]};
                cnt    <= (syncd[g] == lvl_q || acc[g]) ? '0 : cnt + 1'b1;
                lvl_q  <= acc[g] ? syncd[g] : lvl_q;
            end
        end
    end

    // c_cs here is the value held before the edge, so a same-edge cs fall still gates sclk
    assign sclk_en = !(GATE_EDGES && c_cs);

    // edge pulses registered alongside the level flip they report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_pos <= 1'b0;
            sclk_neg <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
        end else begin
            sclk_pos <= acc[0] && syncd[0] && sclk_en;
            sclk_neg <= acc[0] && !syncd[0] && sclk_en;
            cs_fall  <= acc[1] && !syncd[1];
            cs_rise  <= acc[1] && syncd[1];
        end
    end

    assign c_sclk = lvl[0];
    assign c_cs   = lvl[1];
    assign c_mosi = lvl[2];
endmodule

// File: tb/tb_spi_input_frontend.sv
// tb_spi_input_frontend: randomized checks of spi_input_frontend against a sample-window reference model
module tb_spi_input_frontend;
    localparam int S  = 2;
    localparam int WT[3] = '{3, 3, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;
    logic c_sclk, sclk_pos, sclk_neg, c_cs, cs_fall, cs_rise, c_mosi;

    int n_checks = 0;
    int n_fail = 0;

    bit m_lvl [3];
    bit m_rise[3];
    bit m_fall[3];
    bit hist  [3][16];

    spi_input_frontend #(
        .SYNC_STAGES(S), .WAIT_SCLK(WT[0]), .WAIT_CS(WT[1]), .WAIT_MOSI(WT[2]),
        .SCLK_IDLE(1'b0), .GATE_EDGES(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .c_sclk(c_sclk), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
        .c_cs(c_cs), .cs_fall(cs_fall), .cs_rise(cs_rise), .c_mosi(c_mosi)
    );

    always #5 clk = ~clk;

    function automatic bit idle(input int c);
        return c == 1;
    endfunction

    function automatic logic [6:0] obs();
        return {c_sclk, sclk_pos, sclk_neg, c_cs, cs_fall, cs_rise, c_mosi};
    endfunction

    function automatic logic [6:0] expv();
        return {m_lvl[0], m_rise[0], m_fall[0], m_lvl[1], m_fall[1], m_rise[1], m_lvl[2]};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_lvl[c]  = idle(c);
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            for (int i = 0; i < 16; i++) hist[c][i] = idle(c);
        end
    endtask

    // a level is accepted once the raw samples seen SYNC_STAGES..SYNC_STAGES+WAIT-1 edges ago all disagree with it
    task automatic model_step();
        bit raw[3];
        bit old_cs;
        bit flip;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw = '{sclk, cs, mosi};
        old_cs = m_lvl[1];
        for (int c = 0; c < 3; c++) begin
            flip = 1'b1;
            for (int i = S - 1; i <= S + WT[c] - 2; i++)
                if (hist[c][i] == m_lvl[c]) flip = 1'b0;
            m_rise[c] = flip && !m_lvl[c];
            m_fall[c] = flip && m_lvl[c];
            if (flip) m_lvl[c] = !m_lvl[c];
            for (int i = 15; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = raw[c];
        end
        if (old_cs) begin
            m_rise[0] = 1'b0;
            m_fall[0] = 1'b0;
        end
    endtask

    task automatic tick(input bit s, input bit c, input bit m);
        sclk = s;
        cs   = c;
        mosi = m;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if (obs() !== 7'b0001000) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %b expected %b", i, obs(), 7'b0001000);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (obs() !== expv() || obs() !== 7'b0001000) begin
                n_fail++;
                $display("FAIL reset_release cyc%0d: got %b expected %b", i, obs(), 7'b0001000);
            end
        end
    endtask

    task automatic test_cs_fall();
        int falls = 0;
        int rises = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            falls += int'(cs_fall);
            rises += int'(cs_rise);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL cs_fall cyc%0d: got %b expected %b", i, obs(), expv());
            end
            if (i == 4 || i == 5) begin
                n_checks++;
                if ({c_cs, cs_fall} !== ((i == 5) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL cs_fall_latency tick%0d: got c_cs/cs_fall %b%b", i, c_cs, cs_fall);
                end
            end
        end
        n_checks++;
        if (falls != 1 || rises != 0) begin
            n_fail++;
            $display("FAIL cs_fall_count: got fall=%0d rise=%0d expected 1 and 0", falls, rises);
        end
    endtask

    task automatic test_glitch();
        int pos = 0;
        int high = 0;
        for (int i = 0; i < 12; i++) begin
            tick(i < 2, 1'b0, 1'b0);
            pos += int'(sclk_pos);
            high += int'(c_sclk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL glitch cyc%0d: got %b expected %b", i, obs(), expv());
            end
        end
        n_checks++;
        if (pos != 0 || high != 0) begin
            n_fail++;
            $display("FAIL glitch_filter: got pos=%0d c_sclk_high=%0d expected 0 and 0", pos, high);
        end
    endtask

    task automatic test_burst();
        int pos = 0;
        int neg = 0;
        bit m;
        for (int p = 0; p < 8; p++) begin
            m = 1'($urandom);
            for (int j = 0; j < 16; j++) begin
                tick(j < 8, 1'b0, m);
                pos += int'(sclk_pos);
                neg += int'(sclk_neg);
                n_checks++;
                if (obs() !== expv()) begin
                    n_fail++;
                    $display("FAIL burst p%0d j%0d: got %b expected %b", p, j, obs(), expv());
                end
                if (j == 4 || j == 12) begin
                    n_checks++;
                    if ({sclk_pos, sclk_neg} !== ((j == 4) ? 2'b10 : 2'b01)) begin
                        n_fail++;
                        $display("FAIL burst_edge p%0d j%0d: got pos/neg %b%b", p, j, sclk_pos, sclk_neg);
                    end
                end
            end
        end
        n_checks++;
        if (pos != 8 || neg != 8) begin
            n_fail++;
            $display("FAIL burst_count: got pos=%0d neg=%0d expected 8 and 8", pos, neg);
        end
    endtask

    task automatic test_gated();
        int pulses = 0;
        int ups = 0;
        bit prev;
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, mosi);
        prev = c_sclk;
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < 16; j++) begin
                tick(j < 8, 1'b1, mosi);
                pulses += int'(sclk_pos) + int'(sclk_neg);
                ups += int'(c_sclk && !prev);
                prev = c_sclk;
                n_checks++;
                if (obs() !== expv()) begin
                    n_fail++;
                    $display("FAIL gated p%0d j%0d: got %b expected %b", p, j, obs(), expv());
                end
            end
        end
        n_checks++;
        if (pulses != 0 || ups != 8) begin
            n_fail++;
            $display("FAIL gated_count: got pulses=%0d c_sclk_rises=%0d expected 0 and 8", pulses, ups);
        end
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, mosi);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL same_edge cyc%0d: got %b expected %b", i, obs(), expv());
            end
            if (i == 5) begin
                n_checks++;
                if ({c_sclk, sclk_pos, c_cs, cs_fall} !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL same_edge_gate: got c_sclk/pos/c_cs/fall %b%b%b%b expected 1001",
                             c_sclk, sclk_pos, c_cs, cs_fall);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, mosi);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL same_edge_tail cyc%0d: got %b expected %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (c_mosi !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pending: got c_mosi=%b expected 0", c_mosi);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== 7'b0001000) begin
            n_fail++;
            $display("FAIL abort_async: got %b expected %b", obs(), 7'b0001000);
        end
        tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (c_mosi !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold: got c_mosi=%b expected 0", c_mosi);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL abort_release cyc%0d: got %b expected %b", i, obs(), expv());
            end
            if (i == 4 || i == 5) begin
                n_checks++;
                if (c_mosi !== (i == 5)) begin
                    n_fail++;
                    $display("FAIL abort_latency tick%0d: got c_mosi=%b expected %b", i, c_mosi, i == 5);
                end
            end
        end
    endtask

    task automatic test_random();
        bit s, c, m;
        int hold;
        for (int i = 0; i < 500; i++) begin
            if (hold == 0) begin
                s = 1'($urandom);
                c = 1'($urandom);
                m = 1'($urandom);
                hold = $urandom_range(1, 6);
            end
            hold--;
            tick(s, c, m);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b expected %b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cs_fall();
        test_glitch();
        test_burst();
        test_gated();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
